// File: rtl/arbitro_tx_uart.sv
// rtl/arbitro_tx_uart.sv - round-robin arbiter sharing one UART transmitter between two byte requesters
module arbitro_tx_uart #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic [DATA_W-1:0] dato0_i,
    output logic              ack0_o,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] dato1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] tx_dato_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    input  logic              tx_fin_i,
    output logic [1:0]        grant_o,
    output logic              err_timeout_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_FIN,
        S_ACK
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_owner;
    logic [TW-1:0] r_timer;

    logic w_any;
    logic w_pick1;
    logic w_expired;

    // r_last=1 means requester 1 was served last, so requester 0 wins a tie
    assign w_any     = req0_i | req1_i;
    assign w_pick1   = req1_i & (~req0_i | ~r_last);
    assign w_expired = (r_timer == TLAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_owner       <= 1'b0;
            r_timer       <= '0;
            tx_dato_o     <= '0;
            tx_start_o    <= 1'b0;
            ack0_o        <= 1'b0;
            ack1_o        <= 1'b0;
            grant_o       <= 2'b00;
            err_timeout_o <= 1'b0;
        end else begin
            tx_start_o    <= 1'b0;
            ack0_o        <= 1'b0;
            ack1_o        <= 1'b0;
            err_timeout_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_pick1;
                        tx_dato_o  <= w_pick1 ? dato1_i : dato0_i;
                        grant_o    <= w_pick1 ? 2'b10 : 2'b01;
                        tx_start_o <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_FIN: begin
                    // completion beats both the busy edge and the watchdog
                    if (tx_fin_i) begin
                        ack0_o  <= ~r_owner;
                        ack1_o  <= r_owner;
                        r_state <= S_ACK;
                    end else if (w_expired) begin
                        err_timeout_o <= 1'b1;
                        grant_o       <= 2'b00;
                        r_last        <= r_owner;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        if (r_state == S_WAIT_BUSY && tx_busy_i) begin
                            r_state <= S_WAIT_FIN;
                        end
                    end
                end
                S_ACK: begin
                    r_last  <= r_owner;
                    grant_o <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
